// File: rtl/eth_rx_frame_gate.sv
// ---------------------------------------------------------------------------
// eth_rx_frame_gate
//
// Store-and-forward commit/drop gate that sits behind the GMII frame receiver.
// Every received frame is written speculatively into a circular RAM. It only
// becomes visible to the AXI-Stream consumer once its tlast arrives with a
// good FCS (tuser=0). Frames that are bad, do not fit, or arrive while the
// port is disabled are rolled back and never reach the consumer. The output
// side adds the tready backpressure that the receiver itself cannot honour.
//
// Ports
//   clk, rst            single clock, asynchronous active-high reset
//   s_axis_*            receiver stream (no tready; every valid beat is taken)
//   rx_enable           sampled on the first beat of a frame; 0 drops it
//   m_axis_*            committed frames towards the consumer
//   frame_ok            1-cycle pulse, frame committed
//   drop_bad            1-cycle pulse, frame dropped because tuser=1
//   drop_overflow       1-cycle pulse, frame dropped because the buffer filled
//   ok/bad/ovf_count    saturating event counters
// ---------------------------------------------------------------------------
module eth_rx_frame_gate #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  input  logic                  rx_enable,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  frame_ok,
  output logic                  drop_bad,
  output logic                  drop_overflow,
  output logic [CNT_WIDTH-1:0]  ok_count,
  output logic [CNT_WIDTH-1:0]  bad_count,
  output logic [CNT_WIDTH-1:0]  ovf_count
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [PTR_W-1:0] FULL_OCC = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Buffer storage, one entry per beat: {tlast, data}
  logic [DATA_WIDTH:0] r_mem [DEPTH];

  // Write side pointers (speculative and committed) and the overflow flag
  logic [PTR_W-1:0] r_wr_cur;
  logic [PTR_W-1:0] r_wr_commit;
  logic             r_ovf;
  logic             r_resync;

  // Read side: r_rd counts beats handed to the consumer, r_fetch counts RAM reads
  logic [PTR_W-1:0]    r_rd;
  logic [PTR_W-1:0]    r_fetch;
  logic [DATA_WIDTH:0] r_ram_q;
  logic                r_ram_vld;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                r_out_last;
  logic                r_out_valid;

  // Registered status
  logic                 r_frame_ok;
  logic                 r_drop_bad;
  logic                 r_drop_ovf;
  logic [CNT_WIDTH-1:0] r_ok_count;
  logic [CNT_WIDTH-1:0] r_bad_count;
  logic [CNT_WIDTH-1:0] r_ovf_count;

  logic [PTR_W-1:0] w_occupancy;
  logic             w_full;
  logic             w_take;
  logic             w_wr_en;
  logic [PTR_W-1:0] w_wr_cur_nxt;
  logic [PTR_W-1:0] w_wr_commit_nxt;
  logic             w_ovf_nxt;
  logic             w_ok;
  logic             w_bad;
  logic             w_ovfp;
  logic             w_out_load;
  logic             w_out_fire;
  logic             w_fetch;

  // Occupancy counts beats still sitting in the read pipeline, because r_rd
  // only moves on a consumer handshake; this keeps those RAM slots protected.
  assign w_occupancy = r_wr_cur - r_rd;
  assign w_full      = (w_occupancy == FULL_OCC);

  // A beat is stored when it starts an accepted frame or continues one.
  // r_resync marks the first cycle after reset: a beat arriving then is the
  // tail of a frame cut by the reset, so it is never taken as a frame start.
  assign w_take = s_axis_tvalid &&
                  (((r_state == ST_IDLE) && !r_resync && rx_enable) ||
                   (r_state == ST_WRITE));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a beat carrying tlast always ends the frame here, so a
  // dropped 1-beat frame never leaves the FSM waiting in DROP for another tlast.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (s_axis_tvalid && !s_axis_tlast) begin
          if (r_resync || !rx_enable || w_full) begin
            w_state_nxt = ST_DROP;
          end else begin
            w_state_nxt = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (s_axis_tvalid) begin
          if (s_axis_tlast) begin
            w_state_nxt = ST_IDLE;
          end else if (w_full) begin
            w_state_nxt = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: RAM write, pointer updates and event decisions. A full
  // buffer rolls the speculative pointer back; when the offending beat is
  // not the last one, the flag defers the pulse to the frame's tlast.
  always_comb begin
    w_wr_en         = 1'b0;
    w_wr_cur_nxt    = r_wr_cur;
    w_wr_commit_nxt = r_wr_commit;
    w_ovf_nxt       = r_ovf;
    w_ok            = 1'b0;
    w_bad           = 1'b0;
    w_ovfp          = 1'b0;
    if (w_take) begin
      if (w_full) begin
        w_wr_cur_nxt = r_wr_commit;
        if (s_axis_tlast) begin
          w_ovfp = 1'b1;
        end else begin
          w_ovf_nxt = 1'b1;
        end
      end else begin
        w_wr_en = 1'b1;
        if (s_axis_tlast) begin
          if (s_axis_tuser) begin
            w_wr_cur_nxt = r_wr_commit;
            w_bad        = 1'b1;
          end else begin
            w_wr_cur_nxt    = r_wr_cur + PTR_ONE;
            w_wr_commit_nxt = r_wr_cur + PTR_ONE;
            w_ok            = 1'b1;
          end
        end else begin
          w_wr_cur_nxt = r_wr_cur + PTR_ONE;
        end
      end
    end else if ((r_state == ST_DROP) && s_axis_tvalid && s_axis_tlast) begin
      w_ovfp    = r_ovf;
      w_ovf_nxt = 1'b0;
    end
  end

  // Write-side registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_cur    <= '0;
      r_wr_commit <= '0;
      r_ovf       <= 1'b0;
      r_resync    <= 1'b1;
    end else begin
      r_wr_cur    <= w_wr_cur_nxt;
      r_wr_commit <= w_wr_commit_nxt;
      r_ovf       <= w_ovf_nxt;
      r_resync    <= 1'b0;
    end
  end

  // Read pipeline control: the output register refills when empty or when
  // its beat is taken; the RAM stage refills under the same condition.
  assign w_out_fire = r_out_valid && m_axis_tready;
  assign w_out_load = !r_out_valid || m_axis_tready;
  assign w_fetch    = (r_fetch != r_wr_commit) && (!r_ram_vld || w_out_load);

  // Buffer RAM: synchronous write, registered read
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_cur[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end
    if (w_fetch) begin
      r_ram_q <= r_mem[r_fetch[ADDR_WIDTH-1:0]];
    end
  end

  // Read pointers, RAM-stage valid and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch     <= '0;
      r_rd        <= '0;
      r_ram_vld   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_fetch) begin
        r_fetch   <= r_fetch + PTR_ONE;
        r_ram_vld <= 1'b1;
      end else if (w_out_load) begin
        r_ram_vld <= 1'b0;
      end
      if (w_out_load) begin
        r_out_valid <= r_ram_vld;
        if (r_ram_vld) begin
          r_out_last <= r_ram_q[DATA_WIDTH];
          r_out_data <= r_ram_q[DATA_WIDTH-1:0];
        end
      end
      if (w_out_fire) begin
        r_rd <= r_rd + PTR_ONE;
      end
    end
  end

  // Event pulses and saturating counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_ok  <= 1'b0;
      r_drop_bad  <= 1'b0;
      r_drop_ovf  <= 1'b0;
      r_ok_count  <= '0;
      r_bad_count <= '0;
      r_ovf_count <= '0;
    end else begin
      r_frame_ok <= w_ok;
      r_drop_bad <= w_bad;
      r_drop_ovf <= w_ovfp;
      if (w_ok && (r_ok_count != '1)) begin
        r_ok_count <= r_ok_count + CNT_WIDTH'(1);
      end
      if (w_bad && (r_bad_count != '1)) begin
        r_bad_count <= r_bad_count + CNT_WIDTH'(1);
      end
      if (w_ovfp && (r_ovf_count != '1)) begin
        r_ovf_count <= r_ovf_count + CNT_WIDTH'(1);
      end
    end
  end

  assign m_axis_tdata  = r_out_data;
  assign m_axis_tvalid = r_out_valid;
  assign m_axis_tlast  = r_out_last;
  assign frame_ok      = r_frame_ok;
  assign drop_bad      = r_drop_bad;
  assign drop_overflow = r_drop_ovf;
  assign ok_count      = r_ok_count;
  assign bad_count     = r_bad_count;
  assign ovf_count     = r_ovf_count;

endmodule
